mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sits directly downstream of the single-cycle datapath's imem/dmem request ports.
- Merges instruction-fetch and data-access requests onto one shared single-port word-addressed memory bus with variable wait states.
- Generates byte enables, store-lane replication and load-lane extraction; returns ihit/dhit handshakes.
- Detects misaligned data accesses and bus timeouts.

Parameters:
- BUS_TIMEOUT, 255: cycles mem_req may stay high without mem_ready before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- imem_ren  in  1  instruction fetch request
- imem_addr  in  32  fetch byte address (word aligned)
- imem_load  out  32  fetched instruction, valid while ihit=1
- ihit  out  1  one-cycle fetch-complete pulse
- dmem_ren  in  1  data load request
- dmem_wen  in  1  data store request
- dmem_addr  in  32  data byte address
- dmem_store  in  32  store data, LSB-justified
- dmem_width  in  2  00 byte, 01 half, 10 word, 11 treated as word
- dmem_load  out  32  load data, LSB-justified, zero-filled, valid while dhit=1
- dhit  out  1  one-cycle data-complete pulse
- dmem_misalign  out  1  pulses with dhit on a misaligned access
- bus_fault  out  1  pulses with ihit/dhit on a timeout abort
- mem_req  out  1  bus request, registered
- mem_we  out  1  bus write, registered
- mem_addr  out  32  word address {addr[31:2],2'b00}, registered
- mem_wdata  out  32  lane-replicated store data, registered
- mem_be  out  4  byte enables, registered
- mem_rdata  in  32  bus read data, sampled when mem_ready=1
- mem_ready  in  1  bus completion, qualified by mem_req

Behaviour:
- Clock, reset: one clock, clk; reset nrst is asynchronous and active-low.
- Reset values:
  - All outputs are 0 and the FSM is in IDLE.
  - d_done=0, timeout counter=0.
  - Reset mid-transaction abandons the access. No hit is issued.
- FSM states: IDLE, BUSY_I, BUSY_D, RESP.
- IDLE:
  - A data request is pending when (dmem_ren|dmem_wen)&!d_done. Data requests have priority over imem_ren.
  - On grant, the address, width, we and store are latched, mem_* outputs are registered, and the FSM moves to BUSY_D or BUSY_I.
  - Misaligned data access (half with addr[0]=1, word with addr[1:0]!=0): no bus cycle. Go directly to RESP with dmem_misalign=1, dmem_load=0.
- BUSY_x:
  - mem_req=1. The counter increments each cycle.
  - On an edge with mem_ready=1: capture mem_rdata, drop mem_req, go to RESP.
  - If the counter reaches BUS_TIMEOUT (when non-zero): drop mem_req, go to RESP with bus_fault=1 and load data 0.
- RESP:
  - Exactly one of ihit/dhit is 1, along with the captured data. Next state is IDLE.
  - A dhit sets d_done.
- Latency: with zero-wait memory (mem_ready tied 1), a request first seen in cycle 0 gives a hit in cycle 2. Each wait state adds one cycle.
- d_done:
  - Prevents re-issuing the same instruction's data access while dmem_ren/wen stay asserted.
  - Cleared in the cycle ihit=1 (new instruction).
- dmem_wen and dmem_ren both set: a single write, no read.
- Requester inputs are ignored between grant and hit; the latched copies are used.
- Store lanes:
  - byte: wdata = {4{store[7:0]}}, be = 4'b0001<<addr[1:0].
  - half: wdata = {2{store[15:0]}}, be = 4'b0011<<(2*addr[1]).
  - word: wdata = store, be = 4'b1111.
  - Reads drive be = 4'b1111.
- Load lanes:
  - byte: rdata>>(8*addr[1:0]), mask [7:0].
  - half: rdata>>(16*addr[1]), mask [15:0].
  - word: unchanged.
  - Sign extension stays in the datapath.
- Counter: width clog2(BUS_TIMEOUT+1). Cleared on every grant; saturates at its maximum value and does not wrap.

Decomposition:
- rv32ima_pkg gains:
  - mem_width_t enum: MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10.
  - arb_state_t enum: IDLE, BUSY_I, BUSY_D, RESP.
- Sub-module mem_lane_align (combinational): maps width plus addr[1:0] to be/wdata for stores and extracts load lanes. Reused by any future cache.
- Interface mem_arbiter_if groups the core-side and bus-side signals, matching the existing interface style.

Test Plan:
- Zero-wait fetch: imem_ren=1, imem_addr=0x100, mem_ready=1, rdata=0x00500093 -> mem_addr=0x100 in cycle 1; ihit=1 and imem_load=0x00500093 in cycle 2.
- Data priority with d_done: imem_ren and dmem_ren both held high, dmem_addr=0x2002, half -> data access first (dhit), then fetch (ihit). The data access is not repeated until after the ihit.
- Byte store lanes: wen, addr=0x1003, byte, store=0x000000AB -> mem_be=4'b1000, mem_wdata=0xABABABAB, mem_we=1.
- Half load with 3 wait states: addr=0x1002, rdata=0xBEEF1234 -> dhit 5 cycles after the request, dmem_load=0x0000BEEF.
- Misalign: ren, word, addr=0x1001 -> mem_req never asserted; dhit=1 and dmem_misalign=1 in cycle 1, dmem_load=0.
- Timeout and reset: BUS_TIMEOUT=4, mem_ready=0 -> mem_req high for 4 cycles, then hit with bus_fault=1. Repeat with nrst=0 mid-BUSY -> all outputs 0 immediately, no hit.

Source files
------------

// File: rtl/rv32ima_pkg.sv
// Shared types for the core's memory path: access widths and arbiter states.
package rv32ima_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_width_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    // Wait-state counter width; never narrower than one bit so BUS_TIMEOUT=0 still elaborates.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the core-side request ports and the shared memory bus of mem_arbiter.
interface mem_arbiter_if;
    logic        imem_ren;
    logic [31:0] imem_addr;
    logic [31:0] imem_load;
    logic        ihit;
    logic        dmem_ren;
    logic        dmem_wen;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_store;
    logic [1:0]  dmem_width;
    logic [31:0] dmem_load;
    logic        dhit;
    logic        dmem_misalign;
    logic        bus_fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport core (
        output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
        input  imem_load, ihit, dmem_load, dhit, dmem_misalign, bus_fault
    );

    modport bus (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering between LSB-justified core data and a 32-bit word bus.
module mem_lane_align
    import rv32ima_pkg::*;
(
    input  logic [1:0]  width,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] store,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load,
    output logic        misalign
);
    logic [31:0] sh_byte;
    logic [31:0] sh_half;

    assign sh_byte = rdata >> {addr_lo, 3'b000};
    assign sh_half = addr_lo[1] ? {16'h0000, rdata[31:16]} : rdata;

    // Lane replication and enables for stores, lane extraction for loads; 2'b11 acts as word.
    always_comb begin
        be       = 4'b1111;
        wdata    = store;
        load     = rdata;
        misalign = 1'b0;
        case (width)
            MEM_BYTE: begin
                wdata = {4{store[7:0]}};
                load  = {24'h000000, sh_byte[7:0]};
                if (we) be = 4'b0001 << addr_lo;
            end
            MEM_HALF: begin
                wdata    = {2{store[15:0]}};
                load     = {16'h0000, sh_half[15:0]};
                misalign = addr_lo[0];
                if (we) be = addr_lo[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                misalign = |addr_lo;
            end
        endcase
    end
endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction fetches and data accesses onto one single-port word bus.
module mem_arbiter
    import rv32ima_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        imem_ren,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_load,
    output logic        ihit,
    input  logic        dmem_ren,
    input  logic        dmem_wen,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_store,
    input  logic [1:0]  dmem_width,
    output logic [31:0] dmem_load,
    output logic        dhit,
    output logic        dmem_misalign,
    output logic        bus_fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);
    localparam int unsigned CW = cnt_width(BUS_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    arb_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic        d_done_q, d_done_d;
    logic [1:0]  width_q, width_d, alo_q, alo_d;
    logic        we_q, we_d;
    logic        req_q, req_d, mwe_q, mwe_d;
    logic [31:0] maddr_q, maddr_d, wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        ihit_q, ihit_d, dhit_q, dhit_d, mis_q, mis_d, flt_q, flt_d;
    logic [31:0] iload_q, iload_d, dload_q, dload_d;

    logic        data_pend, timeout, is_idle;
    logic [1:0]  la_width, la_alo;
    logic        la_we, la_mis;
    logic [3:0]  la_be;
    logic [31:0] la_wdata, la_load;

    // Live requester inputs steer the lanes at grant; latched copies afterwards.
    assign is_idle   = (state_q == IDLE);
    assign la_width  = is_idle ? dmem_width : width_q;
    assign la_alo    = is_idle ? dmem_addr[1:0] : alo_q;
    assign la_we     = is_idle ? dmem_wen : we_q;
    assign data_pend = (dmem_ren | dmem_wen) & ~d_done_q;
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
    assign timeout   = (BUS_TIMEOUT != 0) && (32'(cnt_inc) == BUS_TIMEOUT);

    mem_lane_align u_lane (
        .width    (la_width),
        .addr_lo  (la_alo),
        .we       (la_we),
        .store    (dmem_store),
        .rdata    (mem_rdata),
        .be       (la_be),
        .wdata    (la_wdata),
        .load     (la_load),
        .misalign (la_mis)
    );

    // Next state plus the next value of every registered output.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        d_done_d = d_done_q;
        width_d  = width_q;
        alo_d    = alo_q;
        we_d     = we_q;
        req_d    = req_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        ihit_d   = 1'b0;
        dhit_d   = 1'b0;
        mis_d    = 1'b0;
        flt_d    = 1'b0;
        iload_d  = 32'h0;
        dload_d  = 32'h0;
        unique case (state_q)
            IDLE: begin
                if (data_pend) begin
                    width_d = dmem_width;
                    alo_d   = dmem_addr[1:0];
                    we_d    = dmem_wen;
                    cnt_d   = '0;
                    if (la_mis) begin
                        state_d = RESP;
                        dhit_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = BUSY_D;
                        req_d   = 1'b1;
                        mwe_d   = dmem_wen;
                        maddr_d = dmem_addr & 32'hFFFF_FFFC;
                        wdata_d = dmem_wen ? la_wdata : 32'h0;
                        be_d    = la_be;
                    end
                end else if (imem_ren) begin
                    state_d = BUSY_I;
                    cnt_d   = '0;
                    req_d   = 1'b1;
                    mwe_d   = 1'b0;
                    maddr_d = imem_addr & 32'hFFFF_FFFC;
                    wdata_d = 32'h0;
                    be_d    = 4'b1111;
                end
            end
            BUSY_I, BUSY_D: begin
                cnt_d = cnt_inc;
                if (mem_ready || timeout) begin
                    state_d = RESP;
                    req_d   = 1'b0;
                    mwe_d   = 1'b0;
                    maddr_d = 32'h0;
                    wdata_d = 32'h0;
                    be_d    = 4'b0000;
                    flt_d   = ~mem_ready;
                    if (state_q == BUSY_I) begin
                        ihit_d  = 1'b1;
                        iload_d = mem_ready ? mem_rdata : 32'h0;
                    end else begin
                        dhit_d  = 1'b1;
                        dload_d = (mem_ready && !we_q) ? la_load : 32'h0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
                if (dhit_q) d_done_d = 1'b1;
                if (ihit_q) d_done_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            d_done_q <= 1'b0;
            width_q  <= 2'b00;
            alo_q    <= 2'b00;
            we_q     <= 1'b0;
            req_q    <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= 32'h0;
            wdata_q  <= 32'h0;
            be_q     <= 4'b0000;
            ihit_q   <= 1'b0;
            dhit_q   <= 1'b0;
            mis_q    <= 1'b0;
            flt_q    <= 1'b0;
            iload_q  <= 32'h0;
            dload_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            d_done_q <= d_done_d;
            width_q  <= width_d;
            alo_q    <= alo_d;
            we_q     <= we_d;
            req_q    <= req_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            ihit_q   <= ihit_d;
            dhit_q   <= dhit_d;
            mis_q    <= mis_d;
            flt_q    <= flt_d;
            iload_q  <= iload_d;
            dload_q  <= dload_d;
        end
    end

    assign mem_req       = req_q;
    assign mem_we        = mwe_q;
    assign mem_addr      = maddr_q;
    assign mem_wdata     = wdata_q;
    assign mem_be        = be_q;
    assign ihit          = ihit_q;
    assign dhit          = dhit_q;
    assign dmem_misalign = mis_q;
    assign bus_fault     = flt_q;
    assign imem_load     = iload_q;
    assign dmem_load     = dload_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected hits, a monitor pops and compares.
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        nrst;
    logic        imem_ren, dmem_ren, dmem_wen;
    logic [31:0] imem_addr, dmem_addr, dmem_store;
    logic [1:0]  dmem_width;
    logic [31:0] imem_load, dmem_load;
    logic        ihit, dhit, dmem_misalign, bus_fault;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    // Bus model knobs
    logic        ready_en;
    int          waits;
    int          bus_cyc;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic        is_i;
        logic [31:0] load;
        logic        mis;
        logic        flt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_arbiter #(.BUS_TIMEOUT(4)) dut (
        .clk           (clk),
        .nrst          (nrst),
        .imem_ren      (imem_ren),
        .imem_addr     (imem_addr),
        .imem_load     (imem_load),
        .ihit          (ihit),
        .dmem_ren      (dmem_ren),
        .dmem_wen      (dmem_wen),
        .dmem_addr     (dmem_addr),
        .dmem_store    (dmem_store),
        .dmem_width    (dmem_width),
        .dmem_load     (dmem_load),
        .dhit          (dhit),
        .dmem_misalign (dmem_misalign),
        .bus_fault     (bus_fault),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_be        (mem_be),
        .mem_rdata     (mem_rdata),
        .mem_ready     (mem_ready)
    );

    assign mem_ready = ready_en && mem_req && (bus_cyc == waits);

    // Counts wait states of the current bus cycle.
    always @(posedge clk or negedge nrst) begin
        if (!nrst) bus_cyc <= 0;
        else if (mem_req && !mem_ready) bus_cyc <= bus_cyc + 1;
        else bus_cyc <= 0;
    end

    // Scoreboard monitor: every hit must match the oldest expectation.
    always @(negedge clk) begin
        if (nrst && (ihit || dhit)) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_hit: got ihit=%0b dhit=%0b, required no hit", ihit, dhit);
            end else begin
                exp_t e;
                logic [31:0] ld;
                e  = sb.pop_front();
                ld = ihit ? imem_load : dmem_load;
                if (ihit !== e.is_i || dhit !== !e.is_i || ld !== e.load ||
                    dmem_misalign !== e.mis || bus_fault !== e.flt) begin
                    n_err++;
                    $display("FAIL hit_response: got ihit=%0b dhit=%0b load=%08h mis=%0b flt=%0b, required ihit=%0b load=%08h mis=%0b flt=%0b",
                             ihit, dhit, ld, dmem_misalign, bus_fault, e.is_i, e.load, e.mis, e.flt);
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic expect_hit(input logic is_i, input logic [31:0] load, input logic mis,
                              input logic flt);
        exp_t e;
        e.is_i = is_i;
        e.load = load;
        e.mis  = mis;
        e.flt  = flt;
        sb.push_back(e);
    endtask

    // Zero-wait fetch; also clears the arbiter's d_done like a new instruction would.
    task automatic fetch(input logic [31:0] a);
        tick();
        imem_ren  = 1'b1;
        imem_addr = a;
        expect_hit(1'b1, mem_rdata, 1'b0, 1'b0);
        tick();
        imem_ren = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        nrst = 1'b0; imem_ren = 1'b0; dmem_ren = 1'b0; dmem_wen = 1'b0;
        imem_addr = 32'h0; dmem_addr = 32'h0; dmem_store = 32'h0; dmem_width = 2'b10;
        mem_rdata = 32'h0; ready_en = 1'b1; waits = 0;
        tick(); tick();
        check("reset_mem_req", {31'h0, mem_req}, 32'h0);
        check("reset_mem_be", {28'h0, mem_be}, 32'h0);
        check("reset_hits", {30'h0, ihit, dhit}, 32'h0);
        nrst = 1'b1;

        // Zero-wait fetch
        tick();
        imem_ren = 1'b1; imem_addr = 32'h100; mem_rdata = 32'h0050_0093;
        expect_hit(1'b1, 32'h0050_0093, 1'b0, 1'b0);
        tick();
        imem_ren = 1'b0;
        check("fetch_mem_req", {31'h0, mem_req}, 32'h1);
        check("fetch_mem_addr", mem_addr, 32'h100);
        tick();
        check("fetch_ihit_c2", {31'h0, ihit}, 32'h1);

        // Data priority and d_done
        tick();
        imem_ren = 1'b1; imem_addr = 32'h200;
        dmem_ren = 1'b1; dmem_addr = 32'h2002; dmem_width = 2'b01; mem_rdata = 32'h1234_5678;
        expect_hit(1'b0, 32'h0000_1234, 1'b0, 1'b0);
        expect_hit(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        expect_hit(1'b0, 32'h0000_1234, 1'b0, 1'b0);
        expect_hit(1'b1, 32'h1234_5678, 1'b0, 1'b0);
        tick();
        check("prio_first_addr", mem_addr, 32'h2000);
        check("prio_read_be", {28'h0, mem_be}, 32'hF);
        check("prio_read_we", {31'h0, mem_we}, 32'h0);
        tick(); tick(); tick();
        check("prio_fetch_after_dhit", mem_addr, 32'h200);
        tick(); tick(); tick();
        check("prio_data_again", mem_addr, 32'h2000);
        tick(); tick(); tick();
        check("prio_fetch_again", mem_addr, 32'h200);
        imem_ren = 1'b0; dmem_ren = 1'b0;
        tick();

        // Byte store lanes
        tick();
        dmem_wen = 1'b1; dmem_addr = 32'h1003; dmem_width = 2'b00; dmem_store = 32'h0000_00AB;
        expect_hit(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        dmem_wen = 1'b0;
        check("sb_be", {28'h0, mem_be}, 32'h8);
        check("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        check("sb_we", {31'h0, mem_we}, 32'h1);
        check("sb_addr", mem_addr, 32'h1000);
        tick();
        fetch(32'h204);

        // Half store, upper lanes
        tick();
        dmem_wen = 1'b1; dmem_addr = 32'h1002; dmem_width = 2'b01; dmem_store = 32'h0000_CDEF;
        expect_hit(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        dmem_wen = 1'b0;
        check("sh_be", {28'h0, mem_be}, 32'hC);
        check("sh_wdata", mem_wdata, 32'hCDEF_CDEF);
        tick();
        fetch(32'h208);

        // Half load with three wait states
        waits = 3;
        tick();
        dmem_ren = 1'b1; dmem_addr = 32'h1002; dmem_width = 2'b01; mem_rdata = 32'hBEEF_1234;
        expect_hit(1'b0, 32'h0000_BEEF, 1'b0, 1'b0);
        tick();
        dmem_ren = 1'b0;
        check("lh_req_c1", {31'h0, mem_req}, 32'h1);
        tick(); tick(); tick();
        check("lh_no_hit_c4", {31'h0, dhit}, 32'h0);
        check("lh_req_c4", {31'h0, mem_req}, 32'h1);
        tick();
        check("lh_dhit_c5", {31'h0, dhit}, 32'h1);
        waits = 0;
        fetch(32'h20C);

        // Byte load from lane 1
        tick();
        dmem_ren = 1'b1; dmem_addr = 32'h1001; dmem_width = 2'b00;
        expect_hit(1'b0, 32'h0000_0012, 1'b0, 1'b0);
        tick();
        dmem_ren = 1'b0;
        check("lb_be", {28'h0, mem_be}, 32'hF);
        tick();
        fetch(32'h210);

        // Misaligned word load
        tick();
        dmem_ren = 1'b1; dmem_addr = 32'h1001; dmem_width = 2'b10;
        expect_hit(1'b0, 32'h0, 1'b1, 1'b0);
        tick();
        dmem_ren = 1'b0;
        check("mis_no_req_c1", {31'h0, mem_req}, 32'h0);
        check("mis_dhit_c1", {31'h0, dhit}, 32'h1);
        tick();
        check("mis_no_req_c2", {31'h0, mem_req}, 32'h0);
        fetch(32'h214);

        // Timeout after four cycles of mem_req
        ready_en = 1'b0;
        tick();
        imem_ren = 1'b1; imem_addr = 32'h300;
        expect_hit(1'b1, 32'h0, 1'b0, 1'b1);
        tick();
        imem_ren = 1'b0;
        check("to_req_c1", {31'h0, mem_req}, 32'h1);
        tick(); tick(); tick();
        check("to_req_c4", {31'h0, mem_req}, 32'h1);
        tick();
        check("to_req_dropped", {31'h0, mem_req}, 32'h0);
        check("to_fault_hit", {30'h0, ihit, bus_fault}, 32'h3);

        // Reset in the middle of a bus cycle
        tick();
        imem_ren = 1'b1; imem_addr = 32'h400;
        tick();
        imem_ren = 1'b0;
        tick();
        check("rst_pre_req", {31'h0, mem_req}, 32'h1);
        nrst = 1'b0;
        #1;
        check("rst_req", {31'h0, mem_req}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_be", {28'h0, mem_be}, 32'h0);
        tick(); tick();
        nrst = 1'b1;
        ready_en = 1'b1;
        tick(); tick(); tick();
        check("rst_no_hit", {30'h0, ihit, dhit}, 32'h0);
        mem_rdata = 32'h0000_0013;
        fetch(32'h404);

        tick(); tick();
        check("scoreboard_drained", sb.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
